// File: rtl/reg_bus_arbiter.sv
// Round-robin arbiter sharing one valid/ready register target among NREQ requesters.
// Grant registered (1 cycle after request); a grant holds while m_ready is low, released on completion or withdrawal.
module reg_bus_arbiter #(
    parameter int NREQ = 4,
    parameter int AW   = 2,
    parameter int DW   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ-1:0]   req_wr,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]   req_ready,
    output logic [DW-1:0]     req_rdata,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_wr,
    output logic [AW-1:0]     m_addr,
    output logic [DW-1:0]     m_wdata,
    input  logic [DW-1:0]     m_rdata,
    output logic [NREQ-1:0]   grant,
    output logic [31:0]       xfer_count
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [IW-1:0] gidx_q, gidx_d;
    logic [IW-1:0] last_q, last_d;
    logic [31:0]   xfer_count_q, xfer_count_d;

    logic [IW-1:0] pick;
    logic          any_vld;
    logic          busy;
    logic          done;

    // Search starts just past the last completed requester so it ends up lowest priority.
    always_comb begin
        pick    = '0;
        any_vld = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!any_vld && req_valid[(int'(last_q) + k) % NREQ]) begin
                any_vld = 1'b1;
                pick    = IW'((int'(last_q) + k) % NREQ);
            end
        end
    end

    assign busy = (state_q == BUSY);

    always_comb begin
        grant   = '0;
        m_valid = 1'b0;
        m_wr    = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        if (busy) begin
            grant[gidx_q] = 1'b1;
            m_valid       = req_valid[gidx_q];
            m_wr          = req_wr[gidx_q];
            m_addr        = req_addr[gidx_q*AW +: AW];
            m_wdata       = req_wdata[gidx_q*DW +: DW];
        end
    end

    assign done       = m_valid & m_ready;
    assign req_ready  = done ? grant : '0;
    assign req_rdata  = m_rdata;
    assign xfer_count = xfer_count_q;

    always_comb begin
        state_d      = state_q;
        gidx_d       = gidx_q;
        last_d       = last_q;
        xfer_count_d = xfer_count_q;
        case (state_q)
            IDLE: begin
                if (any_vld) begin
                    gidx_d  = pick;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                // A requester dropping valid mid-grant abandons the slot without a transfer.
                if (!req_valid[gidx_q]) begin
                    state_d = IDLE;
                end else if (m_ready) begin
                    state_d      = IDLE;
                    last_d       = gidx_q;
                    xfer_count_d = xfer_count_q + 32'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            gidx_q       <= '0;
            last_q       <= IW'(NREQ - 1);
            xfer_count_q <= '0;
        end else begin
            state_q      <= state_d;
            gidx_q       <= gidx_d;
            last_q       <= last_d;
            xfer_count_q <= xfer_count_d;
        end
    end

endmodule
